debug_mem_master: RTL
=====================

# debug_mem_master

Byte-stream debug master that drives the second (debug) ports of the instruction and data RAMs inside the CPU core, so a host link (UART bridge or JTAG shim) can load programs, read back memory and hold the core in reset. It decodes fixed-format command packets from an 8-bit valid/ready input stream, issues word reads and writes on the A2/WD2/WE2/RD2 ports, and returns result bytes on an 8-bit valid/ready output stream. It sits beside the CPU core at the top level and is the initiator for the core's debug memory ports.

## Interface
- RD_LATENCY, 1, cycles from A2 presented to RD2 valid (legal values 1 or 2)
- TIMEOUT, 65535, max idle cycles between bytes of one packet before abort; 0 disables timeout
- clk  in  1  system clock (same clock as the CPU core)
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  host byte available
- in_data  in  8  host byte
- in_ready  out  1  block accepts in_data this cycle
- out_valid  out  1  response byte available
- out_data  out  8  response byte
- out_ready  in  1  host takes out_data this cycle
- iram_a2 / dram_a2  out  32  debug byte address to instruction / data RAM
- iram_wd2 / dram_wd2  out  32  debug write data
- iram_we2 / dram_we2  out  4  debug byte write enables
- iram_rd2 / dram_rd2  in  32  debug read data
- cpu_hold  out  1  request to hold CPU in reset (ORed into CPU_RST at top)
- busy  out  1  high whenever state is not IDLE

## Operation
- Packet = opcode byte, then 4 address bytes little-endian (ops 0x01–0x04), then 4 data bytes little-endian (write ops only).
- 0x01 write IRAM word, 0x02 read IRAM word, 0x03 write DRAM word, 0x04 read DRAM word, 0x10 set cpu_hold, 0x11 clear cpu_hold.
- Address presented as {addr[31:2],2'b00}; addr[1:0] ignored; writes always WE2=4'b1111.
- Write: after last data byte, one cycle with A2/WD2 valid and WE2=4'b1111 on the selected RAM only; then response 0xAA.
- Read: A2 driven on selected RAM, wait RD_LATENCY cycles, capture RD2 into a 32-bit register, respond 4 bytes LE (bits 7:0 first).
- 0x10/0x11: cpu_hold updated in the cycle after opcode accept; response 0xAA.
- Unknown opcode: response 0xEE, no RAM access, no cpu_hold change.
- States: IDLE, ADDR, DATA, WR, RD_WAIT, RESP. IDLE→ADDR (ops 0x01–0x04) / RESP (other); ADDR→DATA (write) or RD_WAIT (read) after 4th byte; DATA→WR after 4th byte; WR→RESP; RD_WAIT→RESP after RD_LATENCY cycles; RESP→IDLE after last byte handshake.
- Byte counter 2 bits, wraps 3→0 between fields; timeout counter 16 bits, cleared on every accepted byte.
- Timeout in ADDR or DATA: discard packet, return to IDLE, no response, no RAM write.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, all A2/WD2=0, all WE2=0, cpu_hold=0, busy=0; first in_ready=1 in the cycle after rst deasserts.
- in_ready=1 only in IDLE/ADDR/DATA; byte accepted on in_valid&in_ready at clk edge.
- out_valid=1 only in RESP; out_data stable while out_valid&!out_ready; next byte presented the cycle after a handshake.
- WE2 nonzero for exactly one cycle per write packet; A2/WD2 hold their last values otherwise.
- Read latency: last address byte accept → RD2 captured RD_LATENCY+1 cycles later → out_valid next cycle.
- Write: last data byte accept → WE2 pulse next cycle → out_valid the cycle after.
- rst mid-packet: abort immediately, outputs to reset values, cpu_hold cleared; no partial write issued.
- in_valid during RESP/WR/RD_WAIT is not accepted (in_ready=0); no bytes lost or duplicated.

## Test plan
- After reset, send 01 00 00 00 00 13 00 00 00 → single iram_we2=4'hF cycle, iram_a2=0, iram_wd2=0x00000013; dram_we2 stays 0; response 0xAA.
- Preload dram word 0x100 = 0xDEADBEEF, send 04 02 01 00 00 (addr 0x102) → dram_a2=0x100; response EF BE AD DE.
- Send 10 → cpu_hold=1, response 0xAA; send 11 → cpu_hold=0, response 0xAA; send 7F → response 0xEE, cpu_hold unchanged.
- With TIMEOUT=8, send 03 04 00 then stall 9 cycles → return to IDLE, no WE2 pulse, no response; next packet 02 00 00 00 00 completes normally.
- Read with out_ready held low 5 cycles per byte, RD_LATENCY=2 → out_data stable while stalled, 4 bytes in order, in_ready=0 throughout RESP.
- Assert rst after 3rd data byte of a 0x01 packet → no iram_we2 pulse, all outputs at reset values next cycle.

Source files
------------

// File: rtl/debug_mem_master_if.sv
// Host byte streams plus the debug-side ports of the instruction and data RAMs.
// The master modport is the debug engine; slave is the host/RAM side.
interface debug_mem_master_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [31:0] iram_a2;
  logic [31:0] iram_wd2;
  logic [3:0]  iram_we2;
  logic [31:0] iram_rd2;
  logic [31:0] dram_a2;
  logic [31:0] dram_wd2;
  logic [3:0]  dram_we2;
  logic [31:0] dram_rd2;
  logic        cpu_hold;
  logic        busy;

  modport master (
    input  in_valid, in_data, out_ready, iram_rd2, dram_rd2,
    output in_ready, out_valid, out_data,
           iram_a2, iram_wd2, iram_we2,
           dram_a2, dram_wd2, dram_we2,
           cpu_hold, busy
  );

  modport slave (
    output in_valid, in_data, out_ready, iram_rd2, dram_rd2,
    input  in_ready, out_valid, out_data,
           iram_a2, iram_wd2, iram_we2,
           dram_a2, dram_wd2, dram_we2,
           cpu_hold, busy
  );
endinterface

// File: rtl/debug_mem_master.sv
// Packet-decoding debug master: host bytes in, word reads/writes on the RAM
// debug ports, result bytes out; also owns the CPU hold request.
module debug_mem_master #(
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 65535
) (
  input logic                clk,
  input logic                rst,
  debug_mem_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD_WAIT, RESP} state_t;

  localparam logic [1:0]  RD_LAST   = 2'(RD_LATENCY);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  localparam logic [7:0]  RESP_OK   = 8'hAA;
  localparam logic [7:0]  RESP_ERR  = 8'hEE;

  state_t      state_q, state_d;
  logic        run_q;
  logic [7:0]  op_q;
  logic [1:0]  cnt_q;
  logic [15:0] tmo_q;
  logic [31:0] addr_q;
  logic [23:0] data_q;
  logic [31:0] resp_q;
  logic        resp_word_q;
  logic        accept;
  logic        op_write;
  logic        op_dram;
  logic        tmo_hit;
  logic        last_byte;
  logic        mem_op_in;

  assign accept    = bus.in_valid && bus.in_ready;
  assign op_write  = (op_q == 8'h01) || (op_q == 8'h03);
  assign op_dram   = (op_q == 8'h03) || (op_q == 8'h04);
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LIMIT);
  assign last_byte = (cnt_q == 2'd3);
  assign mem_op_in = (bus.in_data >= 8'h01) && (bus.in_data <= 8'h04);

  // run_q keeps in_ready low for the first cycle after reset releases
  assign bus.in_ready  = run_q && ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
  assign bus.out_valid = (state_q == RESP);
  assign bus.out_data  = (state_q == RESP) ? resp_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mem_op_in ? ADDR : RESP;
      ADDR: begin
        if (accept && last_byte) state_d = op_write ? DATA : RD_WAIT;
        else if (!accept && tmo_hit) state_d = IDLE;
      end
      DATA: begin
        if (accept && last_byte) state_d = WR;
        else if (!accept && tmo_hit) state_d = IDLE;
      end
      WR:      state_d = RESP;
      RD_WAIT: if (cnt_q == RD_LAST) state_d = RESP;
      RESP:    if (bus.out_ready && (!resp_word_q || last_byte)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      op_q         <= 8'h00;
      cnt_q        <= 2'd0;
      tmo_q        <= 16'h0000;
      addr_q       <= 32'h0;
      data_q       <= 24'h0;
      resp_q       <= 32'h0;
      resp_word_q  <= 1'b0;
      bus.iram_a2  <= 32'h0;
      bus.iram_wd2 <= 32'h0;
      bus.iram_we2 <= 4'h0;
      bus.dram_a2  <= 32'h0;
      bus.dram_wd2 <= 32'h0;
      bus.dram_we2 <= 4'h0;
      bus.cpu_hold <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= 2'd0;
          tmo_q <= 16'h0000;
          if (accept) begin
            op_q <= bus.in_data;
            case (bus.in_data)
              8'h01, 8'h02, 8'h03, 8'h04: begin end
              8'h10: begin
                bus.cpu_hold <= 1'b1;
                resp_q       <= {24'h0, RESP_OK};
                resp_word_q  <= 1'b0;
              end
              8'h11: begin
                bus.cpu_hold <= 1'b0;
                resp_q       <= {24'h0, RESP_OK};
                resp_word_q  <= 1'b0;
              end
              default: begin
                resp_q      <= {24'h0, RESP_ERR};
                resp_word_q <= 1'b0;
              end
            endcase
          end
        end
        ADDR: begin
          if (accept) begin
            tmo_q  <= 16'h0000;
            cnt_q  <= cnt_q + 2'd1;
            addr_q <= {bus.in_data, addr_q[31:8]};
            // Reads present the address as soon as the last byte lands
            if (last_byte && !op_write) begin
              if (op_dram) bus.dram_a2 <= {bus.in_data, addr_q[31:8]} & 32'hFFFF_FFFC;
              else         bus.iram_a2 <= {bus.in_data, addr_q[31:8]} & 32'hFFFF_FFFC;
            end
          end else begin
            tmo_q <= tmo_q + 16'h0001;
          end
        end
        DATA: begin
          if (accept) begin
            tmo_q  <= 16'h0000;
            cnt_q  <= cnt_q + 2'd1;
            data_q <= {bus.in_data, data_q[23:8]};
            if (last_byte) begin
              if (op_dram) begin
                bus.dram_a2  <= addr_q & 32'hFFFF_FFFC;
                bus.dram_wd2 <= {bus.in_data, data_q};
                bus.dram_we2 <= 4'hF;
              end else begin
                bus.iram_a2  <= addr_q & 32'hFFFF_FFFC;
                bus.iram_wd2 <= {bus.in_data, data_q};
                bus.iram_we2 <= 4'hF;
              end
            end
          end else begin
            tmo_q <= tmo_q + 16'h0001;
          end
        end
        WR: begin
          bus.iram_we2 <= 4'h0;
          bus.dram_we2 <= 4'h0;
          resp_q       <= {24'h0, RESP_OK};
          resp_word_q  <= 1'b0;
        end
        RD_WAIT: begin
          // cnt_q counts cycles since the address was presented
          if (cnt_q == RD_LAST) begin
            resp_q      <= op_dram ? bus.dram_rd2 : bus.iram_rd2;
            resp_word_q <= 1'b1;
            cnt_q       <= 2'd0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: begin
          if (bus.out_ready) cnt_q <= cnt_q + 2'd1;
        end
        default: begin end
      endcase
    end
  end
endmodule
